// File: rtl/serial_parallel_align_if.sv
// Lane-side bundle of the serial receiver: the serial bit in, and the aligned
// byte, valid flag and lane-active status out.
interface serial_parallel_align_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in, input data_out, valid_out, active);
  modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_parallel_align.sv
// Per-lane serial-to-parallel receiver: hunts for the COM symbol on any bit
// offset, locks the byte boundary after COM_COUNT aligned COMs, then emits bytes.
module serial_parallel_align #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  serial_parallel_align_if.slave  lane
);

  typedef enum logic [1:0] {HUNT, SYNC, ACTIVE} state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_t     state, state_next;
  // Only the seven most recent bits are kept; the eighth is the incoming bit.
  logic [6:0] sr;
  logic [7:0] nxt;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [3:0] com_cnt, com_cnt_next;
  logic [7:0] data_q, data_next;
  logic       valid_q, valid_next;
  logic       active_q;

  assign nxt            = {sr, lane.data_in};
  assign lane.data_out  = data_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= HUNT;
      sr       <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_next;
      sr       <= nxt[6:0];
      bit_cnt  <= bit_cnt_next;
      com_cnt  <= com_cnt_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      active_q <= (state_next == ACTIVE);
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    com_cnt_next = com_cnt;
    data_next    = data_q;
    valid_next   = valid_q;
    unique case (state)
      HUNT: begin
        bit_cnt_next = 3'd0;
        if (nxt == COM) begin
          com_cnt_next = 4'd1;
          state_next   = (COM_TARGET == 4'd1) ? ACTIVE : SYNC;
        end
      end
      SYNC: begin
        if (bit_cnt == 3'd7) begin
          if (nxt == COM) begin
            com_cnt_next = com_cnt + 4'd1;
            if (com_cnt + 4'd1 == COM_TARGET) state_next = ACTIVE;
          end else begin
            com_cnt_next = 4'd0;
            state_next   = HUNT;
          end
        end
      end
      ACTIVE: begin
        // COM in the data stream is idle fill: keep the last byte, drop valid.
        if (bit_cnt == 3'd7) begin
          if (nxt != COM) begin
            data_next  = nxt;
            valid_next = 1'b1;
          end else begin
            valid_next = 1'b0;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

endmodule

// File: tb/tb_serial_parallel_align.sv
// Self-checking bench for serial_parallel_align: directed lock/offset/idle/reset
// scenarios plus random traffic, all checked against a bit-history model.
module tb_serial_parallel_align;

  localparam logic [7:0] COM       = 8'hBC;
  localparam int         COM_COUNT = 4;

  logic CLK;
  logic RESET;

  serial_parallel_align_if lane ();

  serial_parallel_align #(.COM(COM), .COM_COUNT(COM_COUNT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .lane  (lane.slave)
  );

  int errCount   = 0;
  int checkCount = 0;

  // All bits sampled since the last reset, preceded by eight zeros that stand
  // in for the cleared shift history.
  bit         hist[$];
  bit         seenReset = 0;
  logic       expActive;
  logic       expValid;
  logic [7:0] expData;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] windowAt(int j);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[7-k] = hist[j-7+k];
    return w;
  endfunction

  // Expected outputs derived from the whole history: find a COM on any offset,
  // require COM_COUNT-1 more COMs every 8 bits, otherwise resume the hunt just
  // after the failed byte; once locked, look at every 8th bit after the lock.
  task automatic modelEval(output logic a, output logic v, output logic [7:0] d);
    int  n;
    int  i;
    int  j;
    int  b;
    int  k;
    int  lockEnd;
    bit  searching;
    n = hist.size();
    i = 8;
    lockEnd = -1;
    searching = 1;
    a = 0; v = 0; d = 8'h00;
    while (searching) begin
      j = i;
      while (j < n && windowAt(j) != COM) j++;
      if (j >= n) return;
      b = j;
      k = 1;
      while (k < COM_COUNT) begin
        b += 8;
        if (b >= n) return;
        if (windowAt(b) != COM) break;
        k++;
      end
      if (k == COM_COUNT) begin
        lockEnd = b;
        searching = 0;
      end else begin
        i = b + 1;
      end
    end
    a = 1;
    for (int p = lockEnd + 8; p < n; p += 8) begin
      if (windowAt(p) != COM) begin
        v = 1;
        d = windowAt(p);
      end else begin
        v = 0;
      end
    end
  endtask

  task automatic compare(string name, logic [7:0] act, logic [7:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, just after each rising edge.
  always @(posedge CLK) begin
    if (RESET) begin
      hist.delete();
      for (int z = 0; z < 8; z++) hist.push_back(1'b0);
      seenReset = 1;
    end else if (seenReset) begin
      hist.push_back(lane.data_in);
    end
    #1;
    if (seenReset) begin
      modelEval(expActive, expValid, expData);
      compare("active", {7'd0, lane.active}, {7'd0, expActive});
      compare("valid_out", {7'd0, lane.valid_out}, {7'd0, expValid});
      compare("data_out", lane.data_out, expData);
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic checkOutput(string name, logic a, logic v, logic [7:0] d);
    compare({name, "_dut_active"}, {7'd0, lane.active}, {7'd0, a});
    compare({name, "_dut_valid"}, {7'd0, lane.valid_out}, {7'd0, v});
    compare({name, "_dut_data"}, lane.data_out, d);
    compare({name, "_model"}, {expActive, expValid, 6'd0} ^ expData,
            {a, v, 6'd0} ^ d);
  endtask

  task automatic sendBit(bit b);
    @(negedge CLK);
    RESET = 1'b0;
    lane.data_in = b;
    @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus(logic [7:0] byteVal);
    for (int i = 7; i >= 0; i--) sendBit(byteVal[i]);
  endtask

  task automatic applyReset(int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      RESET = 1'b1;
      lane.data_in = 1'($urandom);
      @(posedge CLK);
      #2;
    end
  endtask

  initial begin
    logic [7:0] tmp;
    int         r;
    RESET = 1'b1;
    lane.data_in = 1'b0;

    // Reset held two cycles with random serial data.
    applyReset(2);
    checkOutput("reset", 1'b0, 1'b0, 8'h00);

    // Aligned lock, then two data bytes.
    repeat (3) applyStimulus(COM);
    tmp = COM;
    for (int i = 7; i >= 1; i--) sendBit(tmp[i]);
    checkOutput("lock_bit31", 1'b0, 1'b0, 8'h00);
    sendBit(tmp[0]);
    checkOutput("lock_bit32", 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h5A);
    checkOutput("lock_5a", 1'b1, 1'b1, 8'h5A);
    applyStimulus(8'h3C);
    checkOutput("lock_3c", 1'b1, 1'b1, 8'h3C);

    // Three garbage bits shift the boundary to offset 3.
    applyReset(2);
    sendBit(1); sendBit(0); sendBit(1);
    repeat (4) applyStimulus(COM);
    checkOutput("offset_bit35", 1'b1, 1'b0, 8'h00);
    applyStimulus(8'hA5);
    checkOutput("offset_a5", 1'b1, 1'b1, 8'hA5);

    // Broken sync, then relock.
    applyReset(2);
    repeat (3) applyStimulus(COM);
    applyStimulus(8'h00);
    checkOutput("broken_bit32", 1'b0, 1'b0, 8'h00);
    repeat (4) applyStimulus(COM);
    checkOutput("broken_relock", 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h11);
    checkOutput("broken_11", 1'b1, 1'b1, 8'h11);

    // Idle COM in the data stream.
    applyReset(2);
    repeat (4) applyStimulus(COM);
    applyStimulus(8'h77);
    checkOutput("idle_77", 1'b1, 1'b1, 8'h77);
    applyStimulus(COM);
    checkOutput("idle_com", 1'b1, 1'b0, 8'h77);
    applyStimulus(8'h22);
    checkOutput("idle_22", 1'b1, 1'b1, 8'h22);

    // Reset in the middle of a byte while ACTIVE.
    tmp = 8'h22;
    for (int i = 7; i >= 4; i--) sendBit(tmp[i]);
    applyReset(1);
    checkOutput("midreset", 1'b0, 1'b0, 8'h00);
    repeat (4) applyStimulus(COM);
    checkOutput("midreset_relock", 1'b1, 1'b0, 8'h00);
    applyStimulus(8'h42);
    checkOutput("midreset_42", 1'b1, 1'b1, 8'h42);

    // Random traffic: stray bits, COM idles, data bytes and occasional resets.
    for (int round = 0; round < 20; round++) begin
      applyReset(2);
      r = $urandom_range(0, 7);
      for (int i = 0; i < r; i++) sendBit(1'($urandom));
      repeat ($urandom_range(3, 6)) applyStimulus(COM);
      for (int item = 0; item < 30; item++) begin
        r = $urandom_range(0, 99);
        if (r < 55) applyStimulus(8'($urandom));
        else if (r < 88) applyStimulus(COM);
        else if (r < 95) sendBit(1'($urandom));
        else applyReset(1);
      end
    end

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
